ifu_prefetch: RTL and testbench

//  Parametrised instruction fetch unit with prefetch queue. Issues in-order fetch requests to

---
 rtl/ifu_pkg.sv | 19 +
 rtl/ifu_fetch_fifo.sv | 60 ++++++
 rtl/ifu_prefetch.sv | 157 +++++++++++++++
 tb/tb_ifu_prefetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned IFU_XLEN = 64;
  localparam int unsigned IFU_ILEN = 32;
  localparam logic [IFU_XLEN-1:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [IFU_XLEN-1:0] pc;
    logic [IFU_ILEN-1:0] inst;
    logic                fault;
  } fq_entry_t;

  // Picks the 32-bit half of an aligned 64-bit fetch word addressed by pc[2].
  function automatic logic [31:0] half_sel(input logic [63:0] data, input logic upper);
    return upper ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Synchronous FIFO with flush; flush beats push, read data is zero while empty.
module ifu_fetch_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fq_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  T                           i_wdata,
  output T                           o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Explicit wrap keeps non-power-of-two depths correct.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: credit-limited in-order fetch into a prefetch queue,
// flushed and restarted on redirect.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = IFU_XLEN,
  parameter int unsigned     ILEN     = IFU_ILEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC),
  parameter int unsigned     FQ_DEPTH = 4,
  parameter int unsigned     MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_en_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [63:0]     imem_resp_data_i,
  input  logic            imem_resp_err_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] if_pc_o,
  output logic [ILEN-1:0] if_inst_o,
  output logic            if_fault_o
);

  localparam int unsigned CW  = $clog2(FQ_DEPTH + 1);
  localparam int unsigned TCW = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            fault;
  } entry_t;

  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_d;
  logic [CW-1:0]   r_out_cnt, w_out_cnt_d;
  logic [CW-1:0]   r_drop_cnt, w_drop_cnt_d;
  logic            r_halt, w_halt_d;

  logic [CW:0]     w_inflight;
  logic            w_req_valid;
  logic            w_accept;
  logic            w_dropping;
  logic            w_keep;
  logic            w_deq;

  entry_t          w_fq_wdata;
  entry_t          w_fq_head;
  logic [CW-1:0]   w_fq_count;
  logic            w_fq_empty;
  logic            w_fq_full;

  logic [XLEN-1:0] w_tag_pc;
  logic [TCW-1:0]  w_tag_count;
  logic            w_tag_empty;
  logic            w_tag_full;
  logic            w_unused;

  // Reserve a queue slot for every live in-flight request so a response always fits.
  assign w_inflight  = {1'b0, r_out_cnt} - {1'b0, r_drop_cnt} + {1'b0, w_fq_count};
  assign w_req_valid = rst_n && !r_halt && !redirect_en_i && (r_out_cnt < CW'(MAX_OUT)) &&
                       (w_inflight < (CW + 1)'(FQ_DEPTH));
  assign w_accept    = w_req_valid && imem_req_ready_i;
  assign w_dropping  = (r_drop_cnt != '0);
  assign w_keep      = imem_resp_valid_i && !w_dropping;
  assign w_deq       = !w_fq_empty && if_ready_i;

  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = {r_fetch_pc[XLEN-1:3], 3'b000};

  assign if_valid_o = !w_fq_empty;
  assign if_pc_o    = w_fq_head.pc;
  assign if_inst_o  = w_fq_head.inst;
  assign if_fault_o = w_fq_head.fault;

  always_comb begin
    w_fq_wdata       = '0;
    w_fq_wdata.pc    = w_tag_pc;
    w_fq_wdata.inst  = ILEN'(half_sel(imem_resp_data_i, w_tag_pc[2]));
    w_fq_wdata.fault = imem_resp_err_i;
  end

  always_comb begin
    w_fetch_pc_d = r_fetch_pc;
    w_out_cnt_d  = r_out_cnt + CW'(w_accept) - CW'(imem_resp_valid_i);
    w_drop_cnt_d = r_drop_cnt;
    w_halt_d     = r_halt;
    if (w_accept) begin
      w_fetch_pc_d = r_fetch_pc + XLEN'(4);
    end
    if (imem_resp_valid_i && w_dropping) begin
      w_drop_cnt_d = r_drop_cnt - CW'(1);
    end
    if (w_keep && imem_resp_err_i) begin
      w_halt_d = 1'b1;
    end
    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_en_i) begin
      w_fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      w_halt_d     = 1'b0;
      w_drop_cnt_d = w_out_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
      r_halt     <= 1'b0;
    end else begin
      r_fetch_pc <= w_fetch_pc_d;
      r_out_cnt  <= w_out_cnt_d;
      r_drop_cnt <= w_drop_cnt_d;
      r_halt     <= w_halt_d;
    end
  end

  ifu_fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .T     (entry_t)
  ) u_fetch_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_keep),
    .i_pop   (w_deq),
    .i_flush (redirect_en_i),
    .i_wdata (w_fq_wdata),
    .o_rdata (w_fq_head),
    .o_count (w_fq_count),
    .o_empty (w_fq_empty),
    .o_full  (w_fq_full)
  );

  // Holds PCs of non-dropped requests only; dropped responses never pop it.
  ifu_fetch_fifo #(
    .DEPTH (MAX_OUT),
    .T     (logic [XLEN-1:0])
  ) u_pc_tags (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_pop   (w_keep),
    .i_flush (redirect_en_i),
    .i_wdata (r_fetch_pc),
    .o_rdata (w_tag_pc),
    .o_count (w_tag_count),
    .o_empty (w_tag_empty),
    .o_full  (w_tag_full)
  );

  assign w_unused = ^{w_fq_full, w_tag_count, w_tag_empty, w_tag_full, redirect_pc_i[1:0]};

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with an in-order 1-cycle memory responder.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_en_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [63:0] imem_resp_data_i;
  logic        imem_resp_err_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [63:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_fault_o;

  int checks   = 0;
  int failures = 0;

  logic        resp_hold = 1'b0;
  logic        err_arm   = 1'b0;
  logic [63:0] err_addr  = '0;
  logic [63:0] pend_q[$];
  logic [63:0] acc_q[$];
  logic [63:0] pop_pc_q[$];
  logic [31:0] pop_inst_q[$];
  logic        pop_fault_q[$];
  int          base_acc;
  int          base_pop;

  always #5 clk = ~clk;

  ifu_prefetch dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .redirect_en_i     (redirect_en_i),
    .redirect_pc_i     (redirect_pc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .imem_resp_err_i   (imem_resp_err_i),
    .if_valid_o        (if_valid_o),
    .if_ready_i        (if_ready_i),
    .if_pc_o           (if_pc_o),
    .if_inst_o         (if_inst_o),
    .if_fault_o        (if_fault_o)
  );

  // Memory word at aligned address a is {~a[31:0], a[31:0]}.
  function automatic logic [31:0] exp_inst(input logic [63:0] pc);
    logic [31:0] w;
    w = {pc[31:3], 3'b000};
    return pc[2] ? ~w : w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(imem_req_valid_o), 64'd0);
    check({tag, "_if_valid"}, 64'(if_valid_o), 64'd0);
    check({tag, "_if_pc"}, if_pc_o, 64'd0);
    check({tag, "_if_inst"}, 64'(if_inst_o), 64'd0);
    check({tag, "_if_fault"}, 64'(if_fault_o), 64'd0);
  endtask

  // Responder: one response per cycle, in order, no earlier than 1 cycle after accept.
  initial begin
    logic [63:0] a;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = '0;
    imem_resp_err_i   = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = '0;
      imem_resp_err_i   = 1'b0;
      if (!rst_n) begin
        pend_q.delete();
      end else begin
        if (!resp_hold && pend_q.size() > 0) begin
          a = pend_q.pop_front();
          imem_resp_valid_i = 1'b1;
          imem_resp_data_i  = {~a[31:0], a[31:0]};
          if (err_arm && a == err_addr) begin
            imem_resp_err_i = 1'b1;
            err_arm = 1'b0;
          end
        end
        if (imem_req_valid_o && imem_req_ready_i) begin
          pend_q.push_back(imem_req_addr_o);
          acc_q.push_back(imem_req_addr_o);
        end
      end
    end
  end

  // Decode-side log of completed handshakes.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && if_valid_o && if_ready_i) begin
        pop_pc_q.push_back(if_pc_o);
        pop_inst_q.push_back(if_inst_o);
        pop_fault_q.push_back(if_fault_o);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    redirect_en_i = 1'b0;
    redirect_pc_i = '0;
    imem_req_ready_i = 1'b0;
    if_ready_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");

    // 1: streaming fetch
    @(negedge clk);
    rst_n = 1'b1;
    imem_req_ready_i = 1'b1;
    if_ready_i = 1'b1;
    #1;
    check("first_req_valid", 64'(imem_req_valid_o), 64'd1);
    check("first_req_addr", imem_req_addr_o, 64'h8000_0000);
    repeat (12) @(negedge clk);
    #1;
    check("acc0", acc_q[0], 64'h8000_0000);
    check("acc1", acc_q[1], 64'h8000_0000);
    check("acc2", acc_q[2], 64'h8000_0008);
    check("pop0_pc", pop_pc_q[0], 64'h8000_0000);
    check("pop1_pc", pop_pc_q[1], 64'h8000_0004);
    check("pop2_pc", pop_pc_q[2], 64'h8000_0008);
    check("pop0_inst", 64'(pop_inst_q[0]), 64'h8000_0000);
    check("pop1_inst", 64'(pop_inst_q[1]), 64'h7FFF_FFFF);
    check("pop2_inst", 64'(pop_inst_q[2]), 64'h8000_0008);

    // 2: decode stall fills the queue, then drains in order
    @(negedge clk);
    if_ready_i = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("stall_if_valid", 64'(if_valid_o), 64'd1);
    check("stall_req_valid", 64'(imem_req_valid_o), 64'd0);
    check("stall_held", 64'(acc_q.size() - pop_pc_q.size()), 64'd4);
    @(negedge clk);
    if_ready_i = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    for (int i = 1; i < pop_pc_q.size(); i++) begin
      check("contig_pc", pop_pc_q[i], pop_pc_q[i-1] + 64'd4);
    end
    for (int i = 0; i < pop_pc_q.size(); i++) begin
      check("stream_inst", 64'(pop_inst_q[i]), 64'(exp_inst(pop_pc_q[i])));
    end

    // 3: redirect with two outstanding requests
    @(negedge clk);
    resp_hold = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("hold_req_valid", 64'(imem_req_valid_o), 64'd0);
    check("hold_outstanding", 64'(pend_q.size()), 64'd2);
    @(negedge clk);
    redirect_en_i = 1'b1;
    redirect_pc_i = 64'h8000_0102;
    #1 check("redir_withdraw", 64'(imem_req_valid_o), 64'd0);
    @(negedge clk);
    redirect_en_i = 1'b0;
    resp_hold = 1'b0;
    base_acc = acc_q.size();
    base_pop = pop_pc_q.size();
    #1 check("redir_q_empty", 64'(if_valid_o), 64'd0);
    repeat (10) @(negedge clk);
    #1;
    check("redir_addr", acc_q[base_acc], 64'h8000_0100);
    check("redir_pc", pop_pc_q[base_pop], 64'h8000_0100);
    check("redir_inst", 64'(pop_inst_q[base_pop]), 64'h8000_0100);

    // 4: fetch fault halts requests until redirect
    @(negedge clk);
    redirect_en_i = 1'b1;
    redirect_pc_i = 64'h8000_0000;
    err_addr = 64'h8000_0008;
    err_arm = 1'b1;
    @(negedge clk);
    redirect_en_i = 1'b0;
    base_acc = acc_q.size();
    base_pop = pop_pc_q.size();
    repeat (15) @(negedge clk);
    #1;
    check("halt_req_valid", 64'(imem_req_valid_o), 64'd0);
    check("halt_accepts", 64'(acc_q.size() - base_acc), 64'd4);
    check("halt_pops", 64'(pop_pc_q.size() - base_pop), 64'd4);
    check("fault0", 64'(pop_fault_q[base_pop]), 64'd0);
    check("fault_pc", pop_pc_q[base_pop+2], 64'h8000_0008);
    check("fault_flag", 64'(pop_fault_q[base_pop+2]), 64'd1);
    check("after_fault_pc", pop_pc_q[base_pop+3], 64'h8000_000C);
    check("after_fault_flag", 64'(pop_fault_q[base_pop+3]), 64'd0);
    @(negedge clk);
    redirect_en_i = 1'b1;
    redirect_pc_i = 64'h8000_0040;
    @(negedge clk);
    redirect_en_i = 1'b0;
    base_pop = pop_pc_q.size();
    #1;
    check("resume_valid", 64'(imem_req_valid_o), 64'd1);
    check("resume_addr", imem_req_addr_o, 64'h8000_0040);
    repeat (6) @(negedge clk);
    #1;
    check("resume_pc", pop_pc_q[base_pop], 64'h8000_0040);
    check("resume_fault", 64'(pop_fault_q[base_pop]), 64'd0);

    // 5: memory back-pressure keeps the request stable; redirect replaces it
    @(negedge clk);
    redirect_en_i = 1'b1;
    redirect_pc_i = 64'h8000_0200;
    imem_req_ready_i = 1'b0;
    @(negedge clk);
    redirect_en_i = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_valid", 64'(imem_req_valid_o), 64'd1);
      check("bp_addr", imem_req_addr_o, 64'h8000_0200);
    end
    @(negedge clk);
    redirect_en_i = 1'b1;
    redirect_pc_i = 64'h8000_0300;
    #1 check("bp_redir_withdraw", 64'(imem_req_valid_o), 64'd0);
    @(negedge clk);
    redirect_en_i = 1'b0;
    #1;
    check("bp_new_valid", 64'(imem_req_valid_o), 64'd1);
    check("bp_new_addr", imem_req_addr_o, 64'h8000_0300);

    // 6: reset in the middle of a burst
    @(negedge clk);
    imem_req_ready_i = 1'b1;
    if_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    resp_hold = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("pre_reset_if_valid", 64'(if_valid_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    resp_hold = 1'b0;
    @(negedge clk);
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    if_ready_i = 1'b1;
    base_pop = pop_pc_q.size();
    #1;
    check("rst_restart_valid", 64'(imem_req_valid_o), 64'd1);
    check("rst_restart_addr", imem_req_addr_o, 64'h8000_0000);
    check("rst_restart_empty", 64'(if_valid_o), 64'd0);
    repeat (6) @(negedge clk);
    #1 check("rst_restart_pc", pop_pc_q[base_pop], 64'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
